vga_tile_renderer: RTL and testbench
====================================

Name: vga_tile_renderer

Overview:
- Generates parametrised VGA timing and renders a tile map held in internal dual-port RAM, one palette-indexed cell per tile.
- Game logic writes cells and palette entries through a synchronous write port, while the renderer streams pixels.
- Sits between game/level logic and the board's VGA pins; replaces the fixed 20-tile, hard-coded-colour renderer.

Parameters:
- H_SYNC, 92, HSync pulse width in clocks
- H_BACK, 50, horizontal back porch
- H_DISPLAY, 640, active pixels per line
- H_FRONT, 18, horizontal front porch
- V_SYNC, 2, VSync pulse width in lines
- V_BACK, 33, vertical back porch
- V_DISPLAY, 480, active lines
- V_FRONT, 10, vertical front porch
- TILE_SHIFT, 5, tile edge = 2^TILE_SHIFT pixels (32)
- MAP_W, 20, tiles per row
- MAP_H, 15, tile rows
- CELL_BITS, 4, bits per cell; the palette has 2^CELL_BITS entries
- COLOR_BITS, 3, bits per colour channel

Ports:
- i_Clk, in, 1, pixel clock
- i_Rst, in, 1, reset: asynchronous, active-high
- i_Cell_WE, in, 1, cell write strobe
- i_Cell_Addr, in, clog2(MAP_W*MAP_H), cell index = row*MAP_W + col
- i_Cell_Data, in, CELL_BITS, cell value (palette index)
- i_Pal_WE, in, 1, palette write strobe
- i_Pal_Idx, in, CELL_BITS, palette entry
- i_Pal_RGB, in, 3*COLOR_BITS, {R,G,B}
- o_VGA_HSync, out, 1, active-low horizontal sync
- o_VGA_VSync, out, 1, active-low vertical sync
- o_VGA_Red, out, COLOR_BITS, red channel
- o_VGA_Grn, out, COLOR_BITS, green channel
- o_VGA_Blu, out, COLOR_BITS, blue channel
- o_Frame_Start, out, 1, one-clock pulse at start of frame

Behaviour:
- Reset (async, i_Rst=1): h/v counters=0; o_VGA_HSync=1, o_VGA_VSync=1; RGB=0; o_Frame_Start=0; pipeline valid bits cleared.
- Palette reset values: 0=black, 1=red (7,0,0), 2=green, 3=blue, all others white. Map RAM is not reset; its contents are undefined until written.
- Counters: h runs 0..H_LINE-1 with H_LINE = sum of horizontal params (800). v increments when h wraps and runs 0..V_FRAME-1 (525).
- Raw sync: HSync low while h<H_SYNC; VSync low while v<V_SYNC.
- Active region: h in [H_SYNC+H_BACK, +H_DISPLAY) and v in [V_SYNC+V_BACK, +V_DISPLAY).
- Pixel coordinates: px = h-(H_SYNC+H_BACK), py likewise; col = px>>TILE_SHIFT, row = py>>TILE_SHIFT.
- Pipeline, 3 stages:
  - S1 registers the cell address row*MAP_W+col and an in-map flag.
  - S2 performs the RAM read.
  - S3 performs the palette lookup into output registers.
- Sync, active and frame-start signals are delayed by the same 3 clocks. The outputs for counter position (h,v) appear exactly 3 clocks after the counters hold (h,v).
- Outside the active region, RGB=0.
- Active but col>=MAP_W or row>=MAP_H: output palette[0].
- Cell write: i_Cell_WE=1 writes RAM at the rising edge; the renderer sees the new value from the next clock.
  - Read/write collision on the same address in the same clock: the renderer gets the old data (read-before-write).
  - Address >= MAP_W*MAP_H: write ignored.
- Palette write: takes effect for S3 lookups from the next clock. Cell and palette writes in the same clock are independent and both complete.
- o_Frame_Start: high for exactly one clock, 3 clocks after the counters reach (0,0).
- Mid-frame reset: all outputs return to reset values immediately. After release, timing restarts at (0,0) and map RAM contents are preserved.

Test Plan:
- Reset: assert i_Rst mid-line -> RGB=0, HSync=VSync=1 and Frame_Start=0 within the same cycle. After release, the first HSync falling edge occurs 3 clocks later.
- Timing: run 2 frames -> HSync low 92 of every 800 clocks; VSync low for 1600 clocks per 420000; Frame_Start every 420000 clocks.
- Cell render: write addr 21 = 2 -> pixels px,py 32..63 are green (0,7,0); px 31 and px 64 on row py=32 follow cells 20 and 22. First green pixel appears 3 clocks after h=174, v=67.
- Palette update: write pal[2]=(5,1,6) during blanking -> the same tile renders (5,1,6) in the next frame; other cells are unchanged.
- Boundaries: write addr 300 -> no RAM change (verify all 300 cells). Same-clock write/read of the rendered address -> old colour on that pixel, new colour on the next frame.
- Blanking: set all palette entries white -> RGB=0 at every non-active h/v position; white across all 640x480 active pixels.

Source files
------------

// File: rtl/vga_tile_renderer.sv
// VGA timing generator with a tile-map renderer: map RAM holds one palette index per
// tile, a small palette register file maps indices to RGB. Three-stage pixel pipeline.
module vga_tile_renderer #(
  parameter int H_SYNC     = 92,
  parameter int H_BACK     = 50,
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 18,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int TILE_SHIFT = 5,
  parameter int MAP_W      = 20,
  parameter int MAP_H      = 15,
  parameter int CELL_BITS  = 4,
  parameter int COLOR_BITS = 3
) (
  input  logic                                 i_Clk,
  input  logic                                 i_Rst,
  input  logic                                 i_Cell_WE,
  input  logic [$clog2(MAP_W*MAP_H)-1:0]       i_Cell_Addr,
  input  logic [CELL_BITS-1:0]                 i_Cell_Data,
  input  logic                                 i_Pal_WE,
  input  logic [CELL_BITS-1:0]                 i_Pal_Idx,
  input  logic [3*COLOR_BITS-1:0]              i_Pal_RGB,
  output logic                                 o_VGA_HSync,
  output logic                                 o_VGA_VSync,
  output logic [COLOR_BITS-1:0]                o_VGA_Red,
  output logic [COLOR_BITS-1:0]                o_VGA_Grn,
  output logic [COLOR_BITS-1:0]                o_VGA_Blu,
  output logic                                 o_Frame_Start
);

  localparam int H_LINE  = H_SYNC + H_BACK + H_DISPLAY + H_FRONT;
  localparam int V_FRAME = V_SYNC + V_BACK + V_DISPLAY + V_FRONT;
  localparam int H_ACT0  = H_SYNC + H_BACK;
  localparam int V_ACT0  = V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_LINE);
  localparam int VW      = $clog2(V_FRAME);
  localparam int CELLS   = MAP_W * MAP_H;
  localparam int AW      = $clog2(CELLS);
  localparam int PAL_N   = 2 ** CELL_BITS;
  localparam int RGB_W   = 3 * COLOR_BITS;
  localparam logic [COLOR_BITS-1:0] C_MAX  = '1;
  localparam logic [COLOR_BITS-1:0] C_ZERO = '0;

  function automatic logic [RGB_W-1:0] pal_default(input int idx);
    case (idx)
      0:       return '0;
      1:       return {C_MAX, C_ZERO, C_ZERO};
      2:       return {C_ZERO, C_MAX, C_ZERO};
      3:       return {C_ZERO, C_ZERO, C_MAX};
      default: return '1;
    endcase
  endfunction

  logic [HW-1:0]        r_h;
  logic [VW-1:0]        r_v;
  logic [HW-1:0]        w_px, w_col;
  logic [VW-1:0]        w_py, w_row;
  logic                 w_active, w_in_map, w_hs, w_vs, w_fs;
  logic [AW-1:0]        w_addr;
  logic                 r_act1, r_map1, r_hs1, r_vs1, r_fs1;
  logic [AW-1:0]        r_addr1;
  logic                 r_act2, r_map2, r_hs2, r_vs2, r_fs2;
  logic [CELL_BITS-1:0] r_cell;
  logic [CELL_BITS-1:0] r_ram [0:CELLS-1];
  logic [RGB_W-1:0]     r_pal [0:PAL_N-1];
  logic [RGB_W-1:0]     w_rgb;
  logic [COLOR_BITS-1:0] r_red, r_grn, r_blu;
  logic                 r_hs3, r_vs3, r_fs3;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == HW'(H_LINE - 1)) begin
      r_h <= '0;
      r_v <= (r_v == VW'(V_FRAME - 1)) ? '0 : r_v + VW'(1);
    end else begin
      r_h <= r_h + HW'(1);
    end
  end

  assign w_px     = r_h - HW'(H_ACT0);
  assign w_py     = r_v - VW'(V_ACT0);
  assign w_col    = w_px >> TILE_SHIFT;
  assign w_row    = w_py >> TILE_SHIFT;
  assign w_active = (int'(r_h) >= H_ACT0) && (int'(r_h) < H_ACT0 + H_DISPLAY) &&
                    (int'(r_v) >= V_ACT0) && (int'(r_v) < V_ACT0 + V_DISPLAY);
  assign w_in_map = (int'(w_col) < MAP_W) && (int'(w_row) < MAP_H);
  // Off-map positions read cell 0 harmlessly; S3 substitutes palette[0] for them.
  assign w_addr   = w_in_map ? (AW'(w_row) * AW'(MAP_W) + AW'(w_col)) : '0;
  assign w_hs     = !(int'(r_h) < H_SYNC);
  assign w_vs     = !(int'(r_v) < V_SYNC);
  assign w_fs     = (r_h == '0) && (r_v == '0);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_act1 <= 1'b0; r_map1 <= 1'b0; r_addr1 <= '0;
      r_hs1  <= 1'b1; r_vs1  <= 1'b1; r_fs1   <= 1'b0;
      r_act2 <= 1'b0; r_map2 <= 1'b0;
      r_hs2  <= 1'b1; r_vs2  <= 1'b1; r_fs2   <= 1'b0;
    end else begin
      r_act1 <= w_active; r_map1 <= w_in_map; r_addr1 <= w_addr;
      r_hs1  <= w_hs;     r_vs1  <= w_vs;     r_fs1   <= w_fs;
      r_act2 <= r_act1;   r_map2 <= r_map1;
      r_hs2  <= r_hs1;    r_vs2  <= r_vs1;    r_fs2   <= r_fs1;
    end
  end

  // Map RAM keeps its contents across reset; registered read returns pre-write data.
  always_ff @(posedge i_Clk) begin
    if (i_Cell_WE && (int'(i_Cell_Addr) < CELLS))
      r_ram[i_Cell_Addr] <= i_Cell_Data;
    r_cell <= r_ram[r_addr1];
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int i = 0; i < PAL_N; i++) r_pal[i] <= pal_default(i);
    end else if (i_Pal_WE) begin
      r_pal[i_Pal_Idx] <= i_Pal_RGB;
    end
  end

  assign w_rgb = r_map2 ? r_pal[r_cell] : r_pal[0];

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      {r_red, r_grn, r_blu} <= '0;
      r_hs3 <= 1'b1; r_vs3 <= 1'b1; r_fs3 <= 1'b0;
    end else begin
      {r_red, r_grn, r_blu} <= r_act2 ? w_rgb : '0;
      r_hs3 <= r_hs2; r_vs3 <= r_vs2; r_fs3 <= r_fs2;
    end
  end

  assign o_VGA_HSync   = r_hs3;
  assign o_VGA_VSync   = r_vs3;
  assign o_VGA_Red     = r_red;
  assign o_VGA_Grn     = r_grn;
  assign o_VGA_Blu     = r_blu;
  assign o_Frame_Start = r_fs3;

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Directed bench for vga_tile_renderer on a shrunken raster (41x30 clocks, 8-pixel tiles,
// 3x2 map) so whole frames fit in a short run.
module tb_vga_tile_renderer;

  localparam int HS = 4, HB = 3, HD = 32, HF = 2;
  localparam int VS = 2, VB = 2, VD = 24, VF = 2;
  localparam int TS = 3, MW = 3, MH = 2, CB = 4, CW = 3;
  localparam int HL = HS + HB + HD + HF;   // 41
  localparam int VL = VS + VB + VD + VF;   // 30
  localparam int FR = HL * VL;             // 1230
  localparam int HA = HS + HB;             // 7
  localparam int VA = VS + VB;             // 4

  logic       clk;
  logic       i_Rst;
  logic       i_Cell_WE;
  logic [2:0] i_Cell_Addr;
  logic [3:0] i_Cell_Data;
  logic       i_Pal_WE;
  logic [3:0] i_Pal_Idx;
  logic [8:0] i_Pal_RGB;
  logic       o_VGA_HSync, o_VGA_VSync, o_Frame_Start;
  logic [2:0] o_VGA_Red, o_VGA_Grn, o_VGA_Blu;

  vga_tile_renderer #(
    .H_SYNC(HS), .H_BACK(HB), .H_DISPLAY(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISPLAY(VD), .V_FRONT(VF),
    .TILE_SHIFT(TS), .MAP_W(MW), .MAP_H(MH), .CELL_BITS(CB), .COLOR_BITS(CW)
  ) dut (
    .i_Clk(clk), .i_Rst(i_Rst),
    .i_Cell_WE(i_Cell_WE), .i_Cell_Addr(i_Cell_Addr), .i_Cell_Data(i_Cell_Data),
    .i_Pal_WE(i_Pal_WE), .i_Pal_Idx(i_Pal_Idx), .i_Pal_RGB(i_Pal_RGB),
    .o_VGA_HSync(o_VGA_HSync), .o_VGA_VSync(o_VGA_VSync),
    .o_VGA_Red(o_VGA_Red), .o_VGA_Grn(o_VGA_Grn), .o_VGA_Blu(o_VGA_Blu),
    .o_Frame_Start(o_Frame_Start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         k;          // clock edges since reset release; outputs show counter k-3
  int         n_checks;
  int         n_err;
  logic [3:0] sh_ram [0:5];
  logic [8:0] sh_pal [0:15];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  function automatic logic [8:0] rgb_now();
    return {o_VGA_Red, o_VGA_Grn, o_VGA_Blu};
  endfunction

  task automatic pal_defaults();
    for (int i = 0; i < 16; i++) sh_pal[i] = 9'o777;
    sh_pal[0] = 9'o000; sh_pal[1] = 9'o700; sh_pal[2] = 9'o070; sh_pal[3] = 9'o007;
  endtask

  // Expected {hsync, vsync, frame_start, rgb} for counter index c.
  function automatic logic [11:0] model(input int c);
    int p, h, v, col, row;
    logic [8:0] rgb;
    p = c % FR; h = p % HL; v = p / HL;
    rgb = 9'o000;
    if (h >= HA && h < HA + HD && v >= VA && v < VA + VD) begin
      col = (h - HA) / 8;
      row = (v - VA) / 8;
      if (col < MW && row < MH) rgb = sh_pal[sh_ram[row * MW + col]];
      else rgb = sh_pal[0];
    end
    return {(h >= HS), (v >= VS), (p == 0), rgb};
  endfunction

  task automatic wr_cell(input int a, input int d);
    $display("write cell %0d = %0d", a, d);
    i_Cell_WE = 1'b1; i_Cell_Addr = 3'(a); i_Cell_Data = 4'(d);
    tick();
    i_Cell_WE = 1'b0;
    if (a < 6) sh_ram[a] = 4'(d);
  endtask

  task automatic wr_pal(input int idx, input logic [8:0] rgb);
    $display("write palette %0d = %o", idx, rgb);
    i_Pal_WE = 1'b1; i_Pal_Idx = 4'(idx); i_Pal_RGB = rgb;
    tick();
    i_Pal_WE = 1'b0;
    sh_pal[idx] = rgb;
  endtask

  task automatic goto_pos(input int c);
    int n = 0;
    while ((((k - 3) % FR) != c) && (n <= FR)) begin
      tick();
      n++;
    end
    if (n > FR) check("goto_timeout", 32'(n), 32'(0));
  endtask

  task automatic pix(input string tag, input int h, input int v, input logic [8:0] exp);
    goto_pos(v * HL + h);
    $display("pixel %s at h=%0d v=%0d: %o", tag, h, v, rgb_now());
    check(tag, 32'(rgb_now()), 32'(exp));
  endtask

  task automatic sweep(input string tag, input int frames, output int hs_low,
                       output int vs_low, output int fs_cnt, output int fs_gap,
                       output int white);
    int bad_rgb = 0, bad_sync = 0, bad_fs = 0, last_fs = -1;
    logic [11:0] e;
    hs_low = 0; vs_low = 0; fs_cnt = 0; fs_gap = 0; white = 0;
    repeat (3) tick();
    for (int i = 0; i < frames * FR; i++) begin
      tick();
      e = model(k - 3);
      if (rgb_now() !== e[8:0]) bad_rgb++;
      if ({o_VGA_HSync, o_VGA_VSync} !== e[11:10]) bad_sync++;
      if (o_Frame_Start !== e[9]) bad_fs++;
      if (o_VGA_HSync == 1'b0) hs_low++;
      if (o_VGA_VSync == 1'b0) vs_low++;
      if (rgb_now() == 9'o777) white++;
      if (o_Frame_Start == 1'b1) begin
        fs_cnt++;
        if (last_fs >= 0) fs_gap = k - last_fs;
        last_fs = k;
      end
    end
    $display("sweep %s: frames=%0d rgb_bad=%0d sync_bad=%0d fs_bad=%0d",
             tag, frames, bad_rgb, bad_sync, bad_fs);
    check({tag, "_rgb"}, 32'(bad_rgb), 32'(0));
    check({tag, "_sync"}, 32'(bad_sync), 32'(0));
    check({tag, "_fs"}, 32'(bad_fs), 32'(0));
  endtask

  initial begin
    int hs_low, vs_low, fs_cnt, fs_gap, white;
    n_checks = 0; n_err = 0; k = 0;
    i_Rst = 1'b1; i_Cell_WE = 1'b0; i_Cell_Addr = '0; i_Cell_Data = '0;
    i_Pal_WE = 1'b0; i_Pal_Idx = '0; i_Pal_RGB = '0;
    pal_defaults();

    repeat (3) @(posedge clk);
    #1;
    $display("reset held");
    check("rst_hs", 32'(o_VGA_HSync), 32'(1));
    check("rst_vs", 32'(o_VGA_VSync), 32'(1));
    check("rst_rgb", 32'(rgb_now()), 32'(0));
    check("rst_fs", 32'(o_Frame_Start), 32'(0));

    i_Rst = 1'b0; k = 0;
    tick(); check("rel_hs_k1", 32'(o_VGA_HSync), 32'(1));
    tick(); check("rel_hs_k2", 32'(o_VGA_HSync), 32'(1));
    tick(); check("rel_hs_fall", 32'(o_VGA_HSync), 32'(0));
    check("rel_fs_k3", 32'(o_Frame_Start), 32'(1));
    tick(); check("rel_fs_k4", 32'(o_Frame_Start), 32'(0));

    wr_cell(0, 1); wr_cell(1, 3); wr_cell(2, 5);
    wr_cell(3, 1); wr_cell(4, 2); wr_cell(5, 3);
    pix("cell4_green", 15, 12, 9'o070);
    pix("cell3_left", 14, 12, 9'o700);
    pix("cell5_right", 23, 12, 9'o007);
    pix("col3_pal0_black", 31, 12, 9'o000);
    wr_pal(0, 9'o123);
    pix("col3_pal0", 31, 12, 9'o123);
    pix("hblank_zero", 40, 12, 9'o000);
    pix("row2_pal0", 7, 20, 9'o123);

    sweep("timing", 2, hs_low, vs_low, fs_cnt, fs_gap, white);
    check("hs_low_clocks", 32'(hs_low), 32'(240));
    check("vs_low_clocks", 32'(vs_low), 32'(164));
    check("fs_count", 32'(fs_cnt), 32'(2));
    check("fs_gap", 32'(fs_gap), 32'(1230));

    goto_pos(28 * HL);
    wr_pal(2, 9'o516);
    pix("cell3_same", 14, 12, 9'o700);
    pix("pal2_new", 15, 12, 9'o516);
    pix("cell1_same", 15, 4, 9'o007);

    wr_cell(6, 2);
    wr_cell(7, 4);
    sweep("oob_write", 1, hs_low, vs_low, fs_cnt, fs_gap, white);

    goto_pos(12 * HL + 15 - 2);
    $display("collision write cell 4 = 1");
    i_Cell_WE = 1'b1; i_Cell_Addr = 3'd4; i_Cell_Data = 4'd1;
    tick();
    i_Cell_WE = 1'b0;
    sh_ram[4] = 4'd1;
    tick(); check("collide_old", 32'(rgb_now()), 32'(9'o516));
    tick(); check("collide_next_clk", 32'(rgb_now()), 32'(9'o700));
    pix("collide_next_frame", 15, 12, 9'o700);

    for (int i = 0; i < 16; i++) wr_pal(i, 9'o777);
    sweep("blanking", 1, hs_low, vs_low, fs_cnt, fs_gap, white);
    check("white_pixels", 32'(white), 32'(768));

    goto_pos(12 * HL + 20);
    check("pre_rst_white", 32'(rgb_now()), 32'(9'o777));
    $display("mid-frame reset");
    i_Rst = 1'b1;
    #1;
    check("midrst_rgb", 32'(rgb_now()), 32'(0));
    check("midrst_hs", 32'(o_VGA_HSync), 32'(1));
    check("midrst_vs", 32'(o_VGA_VSync), 32'(1));
    check("midrst_fs", 32'(o_Frame_Start), 32'(0));
    @(posedge clk); @(posedge clk);
    #1;
    i_Rst = 1'b0; k = 0;
    pal_defaults();
    tick(); check("midrst_hs_k1", 32'(o_VGA_HSync), 32'(1));
    tick();
    tick(); check("midrst_hs_fall", 32'(o_VGA_HSync), 32'(0));
    pix("kept_cell0", 7, 4, 9'o700);
    pix("kept_cell1", 15, 4, 9'o007);
    pix("kept_cell2", 23, 4, 9'o777);
    pix("kept_cell4", 15, 12, 9'o700);
    sweep("after_reset", 1, hs_low, vs_low, fs_cnt, fs_gap, white);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
